seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Iterative unsigned restoring divider. It is the inverse companion to the team's multiply-accumulate datapath, used wherever a MAC result must be scaled back down (for example, normalising an accumulated sum by a count).
- Accepts a DATA_WIDTH-bit dividend and a DIV_WIDTH-bit divisor over a valid/ready handshake.
- Produces one quotient bit per clock.
- Returns the quotient, remainder and a divide-by-zero flag over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 16, dividend and quotient width; also the iteration count.
DIV_WIDTH, 8, divisor and remainder width.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  dividend/divisor are valid this cycle.
in_ready  output  1  divider can accept an operand pair.
dividend  input  DATA_WIDTH  unsigned dividend.
divisor  input  DIV_WIDTH  unsigned divisor.
out_valid  output  1  result registers hold a valid result.
out_ready  input  1  downstream consumes the result.
quotient  output  DATA_WIDTH  unsigned quotient.
remainder  output  DIV_WIDTH  unsigned remainder.
div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE.
  - quotient=0, remainder=0, div_by_zero=0, out_valid=0.
  - in_ready=1 once reset is released; all internal working registers cleared.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept edge = rising edge with in_valid=1. On that edge, latch dividend into a shift register and divisor into a divisor register.
  - Clear the partial remainder (DIV_WIDTH+1 bits) and the iteration counter (clog2(DATA_WIDTH)+1 bits).
  - Nonzero divisor -> RUN. Zero divisor -> DONE with quotient={DATA_WIDTH{1}}, remainder=dividend[DIV_WIDTH-1:0], div_by_zero=1.
- RUN (in_ready=0, out_valid=0), one restoring step per edge:
  - trial = {rem[DIV_WIDTH-1:0], dividend_sr MSB}.
  - If trial >= divisor: rem = trial - divisor, q bit = 1; otherwise rem = trial, q bit = 0.
  - Shift the dividend register left by one; shift the q bit into the quotient LSB.
  - After exactly DATA_WIDTH steps, go to DONE. quotient, remainder = rem[DIV_WIDTH-1:0] and div_by_zero=0 are loaded on that same edge.
- Latency: out_valid rises DATA_WIDTH clock edges after the accept edge (16 by default), or 1 edge after it for a zero divisor.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero are held stable until an edge with out_ready=1, then go to IDLE.
  - Result registers keep their values after the handoff; they are meaningful only while out_valid=1.
- No accept in the same cycle as a result handoff: in_ready rises the cycle after the handoff. Minimum throughput is DATA_WIDTH+2 cycles per operation.
- in_valid is ignored in RUN and DONE; operand changes during RUN have no effect on the result.
- out_ready is ignored outside DONE.
- Arithmetic rules:
  - Purely unsigned.
  - The remainder is always < divisor, so DIV_WIDTH bits suffice.
  - The trial compare/subtract is DIV_WIDTH+1 bits wide and must not truncate.
  - A divisor larger than the dividend gives quotient 0 and remainder = dividend (only possible when the dividend fits in DIV_WIDTH).

Test Plan:
- Accept 1000/7 -> after 16 edges out_valid=1, quotient=142, remainder=6, div_by_zero=0; in_ready=0 throughout RUN.
- 65535/255 then 65535/1 back-to-back with out_ready=1:
  - First result: quotient=257, remainder=0.
  - Second result: quotient=65535, remainder=0.
  - Second accept occurs no earlier than 18 cycles after the first.
- 5/0 -> out_valid 1 edge after accept, quotient=16'hFFFF, remainder=5, div_by_zero=1.
- 100/200 -> quotient=0, remainder=100. Then hold out_ready=0 for 10 cycles while toggling in_valid and operands -> outputs stable, in_ready=0, nothing accepted. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- Reset mid-RUN:
  - Accept 40000/3, assert reset 5 cycles later -> out_valid=0, quotient=0, remainder=0, in_ready=1 after release.
  - A new 9/2 afterwards -> quotient=4, remainder=1.
- Randomised 1000 operand pairs (nonzero divisor) checked against quotient*divisor+remainder==dividend and remainder<divisor.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative unsigned restoring divider, one quotient bit per clock. Used to
//   scale multiply-accumulate results back down, for example to normalise an
//   accumulated sum by a sample count.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for an operand pair; in_ready=1
//   RUN   | one restoring step per edge, DATA_WIDTH steps in total
//   DONE  | result held on quotient/remainder/div_by_zero; out_valid=1
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     operand pair valid            (input handshake)
//   in_ready     divider can accept operands   (input handshake)
//   dividend     DATA_WIDTH-bit unsigned dividend
//   divisor      DIV_WIDTH-bit unsigned divisor
//   out_valid    result registers valid        (output handshake)
//   out_ready    downstream consumes result    (output handshake)
//   quotient     DATA_WIDTH-bit unsigned quotient
//   remainder    DIV_WIDTH-bit unsigned remainder
//   div_by_zero  result came from a zero divisor
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Working registers. The dividend shift register also collects quotient
  // bits at its LSB end: as each dividend bit leaves the top, a quotient bit
  // enters the bottom, so after DATA_WIDTH steps it holds the full quotient.
  logic [DATA_WIDTH-1:0] dividend_sr;
  logic [DIV_WIDTH-1:0]  divisor_reg;
  logic [DIV_WIDTH:0]    rem;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  accept;
  logic                  handoff;
  logic                  last_step;
  logic                  divisor_zero;

  logic [DIV_WIDTH:0]    trial;
  logic [DIV_WIDTH:0]    diff;
  logic                  trial_ge;
  logic                  q_bit;
  logic [DIV_WIDTH:0]    rem_next;
  logic [DATA_WIDTH-1:0] dividend_sr_next;

  assign accept       = (state == IDLE) && in_valid;
  assign handoff      = (state == DONE) && out_ready;
  assign last_step    = (state == RUN) && (cnt == CNT_LAST);
  assign divisor_zero = (divisor == '0);

  // Outputs decoded from state only; no input-to-output combinational path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Restoring step. The compare is done on the full partial remainder so the
  // top bit takes part; it is always zero after a step because the restored
  // remainder stays below the divisor, so this matches comparing trial alone.
  always_comb begin
    trial            = {rem[DIV_WIDTH-1:0], dividend_sr[DATA_WIDTH-1]};
    diff             = trial - {1'b0, divisor_reg};
    trial_ge         = ({rem, dividend_sr[DATA_WIDTH-1]} >= {2'b00, divisor_reg});
    q_bit            = trial_ge;
    rem_next         = trial_ge ? diff : trial;
    dividend_sr_next = {dividend_sr[DATA_WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend_sr <= '0;
      divisor_reg <= '0;
      rem         <= '0;
      cnt         <= '0;
    end else if (accept) begin
      dividend_sr <= dividend;
      divisor_reg <= divisor;
      rem         <= '0;
      cnt         <= '0;
    end else if (state == RUN) begin
      dividend_sr <= dividend_sr_next;
      rem         <= rem_next;
      cnt         <= cnt + 1'b1;
    end
  end

  // Result registers: loaded on the accept edge for a zero divisor, or on the
  // final restoring step otherwise. They are left untouched by the handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && divisor_zero) begin
      quotient    <= '1;
      remainder   <= dividend[DIV_WIDTH-1:0];
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quotient    <= dividend_sr_next;
      remainder   <= rem_next[DIV_WIDTH-1:0];
      div_by_zero <= 1'b0;
    end
  end

  // handoff only drives the state transition; referenced here to document it.
  logic unused_ok;
  assign unused_ok = handoff;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Directed bench for seq_divider with hand-computed results, plus a block of
//   random operand pairs checked by the identity q*d + r == n and r < d.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_divider #(.DATA_WIDTH(16), .DIV_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc      = 0;
  int n_acc    = 0;
  int acc_last = 0;
  int acc_prev = 0;

  // Accept monitor: samples the handshake with pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && in_valid && in_ready) begin
      n_acc    <= n_acc + 1;
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called from IDLE, #1 after an edge. Returns #1 after the accept edge.
  task automatic start(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; also reports whether in_ready stayed low.
  task automatic wait_result(output int lat, output bit ready_low);
    lat       = 0;
    ready_low = 1'b1;
    while (lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [15:0] q;
    logic [7:0]  r;
  } vec_t;

  vec_t vecs[5] = '{
    '{16'd255,   8'd16,  16'd15,  8'd15},
    '{16'd65535, 8'd128, 16'd511, 8'd127},
    '{16'd300,   8'd255, 16'd1,   8'd45},
    '{16'd0,     8'd9,   16'd0,   8'd0},
    '{16'd256,   8'd1,   16'd256, 8'd0}
  };

  initial begin
    int          lat;
    bit          rl;
    int          acc0;
    bit          stable;
    logic [15:0] n;
    logic [7:0]  d;
    logic [31:0] recon;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;

    // 1000 / 7 = 142 r 6
    start(16'd1000, 8'd7);
    wait_result(lat, rl);
    check("t1_latency", lat, 32'd16);
    check("t1_ready_low_run", {31'd0, rl}, 32'd1);
    check("t1_quotient", {16'd0, quotient}, 32'd142);
    check("t1_remainder", {24'd0, remainder}, 32'd6);
    check("t1_dbz", {31'd0, div_by_zero}, 32'd0);
    handoff();

    // Back-to-back 65535/255 then 65535/1 with out_ready held high
    dividend  = 16'd65535;
    divisor   = 8'd255;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    divisor = 8'd1;
    wait_result(lat, rl);
    check("b2b_a_latency", lat, 32'd16);
    check("b2b_a_quotient", {16'd0, quotient}, 32'd257);
    check("b2b_a_remainder", {24'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    check("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat, rl);
    check("b2b_b_latency", lat, 32'd16);
    check("b2b_b_quotient", {16'd0, quotient}, 32'd65535);
    check("b2b_b_remainder", {24'd0, remainder}, 32'd0);
    check("b2b_gap_ge18", {31'd0, (acc_last - acc_prev) >= 18}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_done_idle", {31'd0, in_ready}, 32'd1);

    // 5 / 0
    start(16'd5, 8'd0);
    wait_result(lat, rl);
    check("dz_latency", lat, 32'd1);
    check("dz_quotient", {16'd0, quotient}, 32'hFFFF);
    check("dz_remainder", {24'd0, remainder}, 32'd5);
    check("dz_flag", {31'd0, div_by_zero}, 32'd1);
    handoff();

    // 100 / 200, then hold the result under backpressure
    start(16'd100, 8'd200);
    wait_result(lat, rl);
    check("big_d_quotient", {16'd0, quotient}, 32'd0);
    check("big_d_remainder", {24'd0, remainder}, 32'd100);
    check("big_d_dbz", {31'd0, div_by_zero}, 32'd0);
    acc0   = n_acc;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      dividend = 16'(i * 977);
      divisor  = 8'(i);
      @(posedge clk); #1;
      if (quotient !== 16'd0 || remainder !== 8'd100 || in_ready !== 1'b0 ||
          out_valid !== 1'b1 || div_by_zero !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    check("hold_stable", {31'd0, stable}, 32'd1);
    check("hold_no_accept", n_acc - acc0, 32'd0);
    handoff();

    // Reset in the middle of RUN
    start(16'd40000, 8'd3);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_quotient", {16'd0, quotient}, 32'd0);
    check("mid_rst_remainder", {24'd0, remainder}, 32'd0);
    @(posedge clk); #1;
    start(16'd9, 8'd2);
    wait_result(lat, rl);
    check("post_rst_latency", lat, 32'd16);
    check("post_rst_quotient", {16'd0, quotient}, 32'd4);
    check("post_rst_remainder", {24'd0, remainder}, 32'd1);
    handoff();

    // Directed table
    foreach (vecs[i]) begin
      start(vecs[i].n, vecs[i].d);
      wait_result(lat, rl);
      check($sformatf("vec%0d_quotient", i), {16'd0, quotient}, {16'd0, vecs[i].q});
      check($sformatf("vec%0d_remainder", i), {24'd0, remainder}, {24'd0, vecs[i].r});
      handoff();
    end

    // Random pairs, checked by the division identity
    for (int i = 0; i < 1000; i++) begin
      n = 16'($urandom_range(0, 65535));
      d = 8'($urandom_range(1, 255));
      start(n, d);
      wait_result(lat, rl);
      recon = 32'(quotient) * 32'(d) + 32'(remainder);
      check($sformatf("rnd%0d_identity", i), recon, {16'd0, n});
      check($sformatf("rnd%0d_rem_lt_div", i), {31'd0, remainder < d}, 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
